// File: rtl/fractal_sync_rsp_arb.sv
// -----------------------------------------------------------------------------
// fractal_sync_rsp_arb
//
// Round-robin arbiter that drains N synchronization-response FIFOs onto one
// registered valid/ready response channel. It also folds the per-FIFO
// overflow error pulses into a sticky flag and a saturating event counter.
//
// Ports:
//   clk_i         clock (single domain)
//   rst_ni        asynchronous active-low reset
//   empty_i       per-FIFO empty flag (0 = FIFO holds a response)
//   rsp_i         head element of each FIFO (combinational FIFO output)
//   pop_o         one-hot (or zero) pop strobe back to the FIFOs
//   overflow_i    per-FIFO overflow error pulse
//   rsp_o         registered output response (payload passed through untouched)
//   valid_o       rsp_o holds a response
//   ready_i       downstream accepts rsp_o
//   src_o         index of the FIFO rsp_o came from
//   err_sticky_o  set by any overflow, cleared by err_clr_i or reset
//   err_cnt_o     saturating count of overflow events
//   err_clr_i     synchronous clear of err_sticky_o / err_cnt_o
// -----------------------------------------------------------------------------
module fractal_sync_rsp_arb #(
    parameter type         fsync_rsp_t = logic,
    parameter int unsigned N_PORTS     = 2,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_PORTS-1:0]           empty_i,
    input  fsync_rsp_t                   rsp_i [N_PORTS],
    output logic [N_PORTS-1:0]           pop_o,
    input  logic [N_PORTS-1:0]           overflow_i,
    output fsync_rsp_t                   rsp_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [$clog2(N_PORTS)-1:0]   src_o,
    output logic                         err_sticky_o,
    output logic [ERR_CNT_W-1:0]         err_cnt_o,
    input  logic                         err_clr_i
);

    localparam int unsigned IDX_W = $clog2(N_PORTS);
    localparam int unsigned PC_W  = $clog2(N_PORTS + 1);
    localparam int unsigned SUM_W = ERR_CNT_W + PC_W;

    localparam logic [IDX_W:0]         N_PORTS_L = (IDX_W + 1)'(N_PORTS);
    localparam logic [N_PORTS-1:0]     ONE_HOT_0 = N_PORTS'(1);
    localparam logic [SUM_W-1:0]       CNT_MAX_L = SUM_W'({ERR_CNT_W{1'b1}});

    // A single requester would make the arbiter degenerate; refuse to elaborate.
    if (N_PORTS < 32'd2) begin : g_bad_n_ports
        $fatal(1, "fractal_sync_rsp_arb: N_PORTS must be >= 2");
    end

    // (base + off) mod N_PORTS, valid for base < N_PORTS and off <= N_PORTS
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [IDX_W:0]   off);
        logic [IDX_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= N_PORTS_L) begin
            sum = sum - N_PORTS_L;
        end else begin
            sum = sum;
        end
        return sum[IDX_W-1:0];
    endfunction

    // Number of set bits in an overflow vector
    function automatic logic [PC_W-1:0] popcount(input logic [N_PORTS-1:0] vec);
        logic [PC_W-1:0] cnt;
        cnt = {PC_W{1'b0}};
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            cnt = cnt + PC_W'(vec[i]);
        end
        return cnt;
    endfunction

    logic [N_PORTS-1:0] w_req;
    logic               w_free;
    logic               w_found;
    logic               w_grant_vld;
    logic [IDX_W-1:0]   w_grant_idx;
    logic [SUM_W-1:0]   w_cnt_sum;
    logic [ERR_CNT_W-1:0] w_cnt_nxt;

    fsync_rsp_t         r_rsp;
    logic               r_valid;
    logic [IDX_W-1:0]   r_src;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_sticky;
    logic [ERR_CNT_W-1:0] r_cnt;

    assign w_req  = ~empty_i;
    // The output slot can take a new response when empty or being drained now.
    assign w_free = ~r_valid | ready_i;

    // Priority search starting at the round-robin pointer, wrapping at N_PORTS-1
    always_comb begin
        w_grant_idx = r_ptr;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (!w_found && w_req[wrap_add(r_ptr, (IDX_W + 1)'(i))]) begin
                w_grant_idx = wrap_add(r_ptr, (IDX_W + 1)'(i));
                w_found     = 1'b1;
            end else begin
                w_found     = w_found;
            end
        end
    end

    // Gating with rst_ni keeps pops silent while reset is asserted, even though
    // the output slot reads as free then.
    assign w_grant_vld = rst_ni & w_free & w_found;

    // Pop strobe: one-hot on the granted FIFO, otherwise zero
    always_comb begin
        if (w_grant_vld) begin
            pop_o = ONE_HOT_0 << w_grant_idx;
        end else begin
            pop_o = {N_PORTS{1'b0}};
        end
    end

    // Output register, source index and round-robin pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rsp   <= fsync_rsp_t'(0);
            r_valid <= 1'b0;
            r_src   <= {IDX_W{1'b0}};
            r_ptr   <= {IDX_W{1'b0}};
        end else if (w_grant_vld) begin
            r_rsp   <= rsp_i[w_grant_idx];
            r_valid <= 1'b1;
            r_src   <= w_grant_idx;
            r_ptr   <= wrap_add(w_grant_idx, (IDX_W + 1)'(1));
        end else if (r_valid && ready_i) begin
            // Handshake with nothing to refill: slot empties, payload kept.
            r_rsp   <= r_rsp;
            r_valid <= 1'b0;
            r_src   <= r_src;
            r_ptr   <= r_ptr;
        end else begin
            r_rsp   <= r_rsp;
            r_valid <= r_valid;
            r_src   <= r_src;
            r_ptr   <= r_ptr;
        end
    end

    // Saturating next count; the sum is wide enough that it can never wrap
    always_comb begin
        w_cnt_sum = SUM_W'(r_cnt) + SUM_W'(popcount(overflow_i));
        if (w_cnt_sum > CNT_MAX_L) begin
            w_cnt_nxt = {ERR_CNT_W{1'b1}};
        end else begin
            w_cnt_nxt = w_cnt_sum[ERR_CNT_W-1:0];
        end
    end

    // Overflow accounting; a clear wins over same-cycle overflow events
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sticky <= 1'b0;
            r_cnt    <= {ERR_CNT_W{1'b0}};
        end else if (err_clr_i) begin
            r_sticky <= 1'b0;
            r_cnt    <= {ERR_CNT_W{1'b0}};
        end else if (|overflow_i) begin
            r_sticky <= 1'b1;
            r_cnt    <= w_cnt_nxt;
        end else begin
            r_sticky <= r_sticky;
            r_cnt    <= r_cnt;
        end
    end

    assign rsp_o        = r_rsp;
    assign valid_o      = r_valid;
    assign src_o        = r_src;
    assign err_sticky_o = r_sticky;
    assign err_cnt_o    = r_cnt;

endmodule

// File: tb/tb_fractal_sync_rsp_arb.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for fractal_sync_rsp_arb (N_PORTS=2,
// ERR_CNT_W=2). Two queues act as the source FIFOs; expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_fractal_sync_rsp_arb;

    typedef struct packed {
        logic       wake;
        logic [3:0] dst;
        logic       error;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] empty_in;
    rsp_t       rsp_in [2];
    logic [1:0] pop;
    logic [1:0] overflow;
    rsp_t       rsp_out;
    logic       valid;
    logic       ready;
    logic       src;
    logic       sticky;
    logic [1:0] cnt;
    logic       clr;

    int n_chk = 0;
    int n_err = 0;

    rsp_t q0[$];
    rsp_t q1[$];

    always #5 clk = ~clk;

    fractal_sync_rsp_arb #(
        .fsync_rsp_t (rsp_t),
        .N_PORTS     (2),
        .ERR_CNT_W   (2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .empty_i      (empty_in),
        .rsp_i        (rsp_in),
        .pop_o        (pop),
        .overflow_i   (overflow),
        .rsp_o        (rsp_out),
        .valid_o      (valid),
        .ready_i      (ready),
        .src_o        (src),
        .err_sticky_o (sticky),
        .err_cnt_o    (cnt),
        .err_clr_i    (clr)
    );

    function automatic rsp_t mk(input logic w, input logic [3:0] d, input logic e);
        rsp_t r;
        r.wake  = w;
        r.dst   = d;
        r.error = e;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present queue heads / empty flags to the DUT
    task automatic drive();
        empty_in[0] = (q0.size() == 0);
        empty_in[1] = (q1.size() == 0);
        rsp_in[0]   = (q0.size() != 0) ? q0[0] : rsp_t'(0);
        rsp_in[1]   = (q1.size() != 0) ? q1[0] : rsp_t'(0);
    endtask

    // One clock: pops sampled before the edge take effect after it
    task automatic tick();
        logic [1:0] p;
        p = pop;
        @(posedge clk);
        #1;
        if (p[0] && q0.size() != 0) void'(q0.pop_front());
        if (p[1] && q1.size() != 0) void'(q1.pop_front());
        drive();
        #1;
    endtask

    rsp_t ra, rb[3], rc[3], rd[2], re, rf0, rf1, rg0, rg1;

    initial begin
        rst_n    = 1'b0;
        ready    = 1'b1;
        overflow = 2'b00;
        clr      = 1'b0;
        drive();

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  32'(valid),   32'd0);
        chk("rst_rsp",    32'(rsp_out), 32'd0);
        chk("rst_src",    32'(src),     32'd0);
        chk("rst_pop",    32'(pop),     32'd0);
        chk("rst_sticky", 32'(sticky),  32'd0);
        chk("rst_cnt",    32'(cnt),     32'd0);
        rst_n = 1'b1;
        #1;

        // ---------------- idle ----------------
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", 32'(valid), 32'd0);
            chk("idle_pop",   32'(pop),   32'd0);
            chk("idle_cnt",   32'(cnt),   32'd0);
        end

        // ---------------- single port ----------------
        ra = mk(1'b1, 4'h5, 1'b0);
        q1.push_back(ra);
        drive();
        #1;
        chk("single_pop", 32'(pop), 32'h2);
        tick();
        chk("single_valid", 32'(valid),   32'd1);
        chk("single_rsp",   32'(rsp_out), 32'(ra));
        chk("single_src",   32'(src),     32'd1);
        chk("single_pop0",  32'(pop),     32'd0);
        tick();
        chk("single_drain", 32'(valid),   32'd0);

        // ---------------- round robin ----------------
        for (int i = 0; i < 3; i++) begin
            rb[i] = mk(1'b0, 4'(i + 1), 1'(i));
            rc[i] = mk(1'b1, 4'(i + 8), 1'b1);
            q0.push_back(rb[i]);
            q1.push_back(rc[i]);
        end
        drive();
        #1;
        chk("rr_pop_first", 32'(pop), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_valid", 32'(valid), 32'd1);
            chk("rr_src",   32'(src),   32'(i % 2));
            chk("rr_rsp",   32'(rsp_out), 32'((i % 2 == 0) ? rb[i / 2] : rc[i / 2]));
            chk("rr_pop",   32'(pop),   (i < 5) ? (32'd1 << ((i + 1) % 2)) : 32'd0);
        end
        tick();
        chk("rr_drain", 32'(valid), 32'd0);

        // ---------------- backpressure ----------------
        rd[0] = mk(1'b1, 4'h3, 1'b0);
        rd[1] = mk(1'b0, 4'hc, 1'b1);
        re    = mk(1'b1, 4'ha, 1'b1);
        q0.push_back(rd[0]);
        q0.push_back(rd[1]);
        q1.push_back(re);
        drive();
        #1;
        chk("bp_pop_first", 32'(pop), 32'h1);
        tick();
        ready = 1'b0;
        #1;
        chk("bp_rsp0", 32'(rsp_out), 32'(rd[0]));
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_pop",   32'(pop),     32'd0);
            chk("bp_hold_rsp",   32'(rsp_out), 32'(rd[0]));
            chk("bp_hold_src",   32'(src),     32'd0);
            chk("bp_hold_valid", 32'(valid),   32'd1);
            tick();
        end
        ready = 1'b1;
        #1;
        chk("bp_release_pop", 32'(pop), 32'h2);
        tick();
        chk("bp_rsp1", 32'(rsp_out), 32'(re));
        chk("bp_src1", 32'(src),     32'd1);
        chk("bp_pop2", 32'(pop),     32'h1);
        tick();
        chk("bp_rsp2", 32'(rsp_out), 32'(rd[1]));
        chk("bp_src2", 32'(src),     32'd0);
        chk("bp_pop3", 32'(pop),     32'd0);
        tick();
        chk("bp_drain", 32'(valid), 32'd0);

        // ---------------- overflow counting ----------------
        overflow = 2'b11;
        tick();
        overflow = 2'b00;
        #1;
        chk("ovf_cnt2",    32'(cnt),    32'd2);
        chk("ovf_sticky",  32'(sticky), 32'd1);
        overflow = 2'b11;
        tick();
        overflow = 2'b00;
        #1;
        chk("ovf_cnt_sat", 32'(cnt), 32'd3);
        overflow = 2'b11;
        tick();
        overflow = 2'b00;
        #1;
        chk("ovf_no_wrap", 32'(cnt), 32'd3);
        tick();
        chk("ovf_sticky_hold", 32'(sticky), 32'd1);
        chk("ovf_cnt_hold",    32'(cnt),    32'd3);
        clr      = 1'b1;
        overflow = 2'b01;
        tick();
        clr      = 1'b0;
        overflow = 2'b00;
        #1;
        chk("clr_cnt",    32'(cnt),    32'd0);
        chk("clr_sticky", 32'(sticky), 32'd0);

        // ---------------- mid-operation reset ----------------
        // Pointer is 1 here (last grant went to port 0).
        rf0 = mk(1'b0, 4'h1, 1'b0);
        rf1 = mk(1'b1, 4'h2, 1'b1);
        rg0 = mk(1'b1, 4'he, 1'b0);
        rg1 = mk(1'b0, 4'hf, 1'b1);
        q0.push_back(rf0);
        q1.push_back(rg0);
        q1.push_back(rg1);
        ready = 1'b0;
        drive();
        #1;
        chk("mr_pop_ptr1", 32'(pop), 32'h2);
        tick();
        chk("mr_rsp_g0", 32'(rsp_out), 32'(rg0));
        ready = 1'b1;
        #1;
        chk("mr_pop_ptr0", 32'(pop), 32'h1);
        tick();
        ready = 1'b0;
        overflow = 2'b01;
        q0.push_back(rf1);
        drive();
        #1;
        chk("mr_rsp_f0", 32'(rsp_out), 32'(rf0));
        tick();
        overflow = 2'b00;
        #1;
        chk("mr_cnt_pre",   32'(cnt),   32'd1);
        chk("mr_valid_pre", 32'(valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid_async", 32'(valid),  32'd0);
        chk("mr_pop_in_rst",  32'(pop),    32'd0);
        chk("mr_cnt_rst",     32'(cnt),    32'd0);
        chk("mr_sticky_rst",  32'(sticky), 32'd0);
        tick();
        chk("mr_valid_hold_rst", 32'(valid), 32'd0);
        chk("mr_pop_hold_rst",   32'(pop),   32'd0);
        ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("mr_pop_after", 32'(pop), 32'h1);
        tick();
        chk("mr_rsp_f1", 32'(rsp_out), 32'(rf1));
        chk("mr_src_f1", 32'(src),     32'd0);
        chk("mr_pop_g1", 32'(pop),     32'h2);
        tick();
        chk("mr_rsp_g1", 32'(rsp_out), 32'(rg1));
        chk("mr_src_g1", 32'(src),     32'd1);
        tick();
        chk("mr_drain", 32'(valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fractal_sync_rsp_arb.md
Name: fractal_sync_rsp_arb

Overview:
- Round-robin arbiter that drains N synchronization-response FIFOs (e.g. the en/ws tx FIFO outputs of several nodes) onto one registered response channel with a valid/ready handshake.
- Sits between tx datapath FIFOs and a shared downstream response link; issues the FIFO pop strobes.
- Also aggregates FIFO overflow error pulses into a sticky flag and a saturating counter.

Parameters:
- fsync_rsp_t, logic, response struct with fields wake, dst, error; forwarded unmodified.
- N_PORTS, 2, number of requesting FIFOs; must be >= 2 (assert, $fatal otherwise).
- ERR_CNT_W, 8, width of the overflow error counter.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- empty_i  in  N_PORTS  per-FIFO empty flag; bit k=0 means FIFO k holds a response.
- rsp_i  in  N_PORTS x $bits(fsync_rsp_t)  head element of each FIFO (combinational FIFO output).
- pop_o  out  N_PORTS  one-hot pop strobe to the FIFOs.
- overflow_i  in  N_PORTS  per-FIFO overflow error pulse.
- rsp_o  out  $bits(fsync_rsp_t)  registered output response.
- valid_o  out  1  rsp_o holds a response.
- ready_i  in  1  downstream accepts rsp_o.
- src_o  out  $clog2(N_PORTS)  index of the FIFO rsp_o came from.
- err_sticky_o  out  1  set by any overflow; cleared only by err_clr_i or reset.
- err_cnt_o  out  ERR_CNT_W  saturating count of overflow events.
- err_clr_i  in  1  synchronous clear of err_sticky_o and err_cnt_o.

Behaviour:
- Reset: valid_o=0, rsp_o='0, src_o=0, pop_o=0, err_sticky_o=0, err_cnt_o=0, priority pointer=0.
- Output register is free when valid_o=0, or when valid_o=1 and ready_i=1 in the same cycle (full-throughput, no bubble).
- Requesters: req[k] = ~empty_i[k].
- Grant (combinational): the first k with req[k]=1, searching from the pointer upward with wrap-around at N_PORTS-1 -> 0.
- Grant is issued only when the output register is free and at least one req is set.
- On a grant to k, in the same cycle:
  - pop_o[k]=1; all other pop bits 0; pop_o is always one-hot or zero.
  - Next edge: rsp_o<=rsp_i[k], src_o<=k, valid_o<=1.
  - Pointer <= (k+1) mod N_PORTS.
- No grant while the register is held (valid_o=1, ready_i=0): pop_o=0; rsp_o, src_o and pointer stay stable.
- valid_o falls to 0 after a handshake only when no new grant is issued in that cycle.
- Latency: FIFO non-empty in cycle t -> valid_o in cycle t+1 when the register is free. Throughput is 1 response/cycle with ready_i tied high.
- Fairness: with all N_PORTS FIFOs continuously non-empty, each is served exactly once every N_PORTS grants.
- Payload: rsp_i contents are never inspected or modified; the error field is passed through.
- No pop to an empty FIFO under any condition.
- Overflow accounting:
  - Per cycle, if any overflow_i bit is set, err_sticky_o<=1.
  - err_cnt_o increments by popcount(overflow_i), saturating at 2^ERR_CNT_W-1; it never wraps.
  - err_clr_i has priority: in a cycle with both err_clr_i and overflows, the next state is 0/0 and the simultaneous events are dropped.
- Reset mid-operation: all state returns to reset values asynchronously. An in-flight rsp_o is discarded; no pop is issued while rst_ni=0.

Test Plan:
- Reset then idle: empty_i=2'b11, ready_i=1 for 10 cycles -> valid_o=0, pop_o=0, err_cnt_o=0 throughout.
- Single port: FIFO1 holds A (dst=4'h5) -> pop_o=2'b10 in cycle t; next cycle valid_o=1, rsp_o=A, src_o=1; then valid_o=0.
- Round-robin, N_PORTS=2, both FIFOs with 3 entries each, ready_i=1 -> src_o sequence 0,1,0,1,0,1 on consecutive cycles, six pops, no bubbles.
- Backpressure: valid_o=1, ready_i=0 for 5 cycles with both FIFOs non-empty -> pop_o=0 and rsp_o stable. ready_i=1 -> in that same cycle pop_o shows the next grant in pointer order, and the next entry appears one cycle later.
- Overflow counting, ERR_CNT_W=2: overflow_i=2'b11 for 1 cycle -> err_cnt_o=2, sticky=1. A further 2'b11 -> err_cnt_o=3 (saturated). err_clr_i together with overflow_i=2'b01 -> 0/0.
- Mid-operation reset: rst_ni pulled low while valid_o=1, ready_i=0 -> valid_o=0 immediately. After release, the pointer restarts at 0 and port 0 is granted first.
